// File: rtl/mmio_wr_fifo.sv
// mmio_wr_fifo: 64-bit MMIO-mapped queue behind the AFU's CCI-P MMIO decode.
// Host writes to DATA_ADDR push a word. Host reads of DATA_ADDR pop a word.
// STATUS_ADDR reads back occupancy and sticky flags.
// CTRL_ADDR writes can flush the queue and/or clear the sticky flags.
// Every read answers exactly one clock later on rd_hit/rd_data.
module mmio_wr_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DATA_ADDR   = 16'h0020,
  parameter logic [15:0] STATUS_ADDR = 16'h0022,
  parameter logic [15:0] CTRL_ADDR   = 16'h0024,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic          rd_valid,
  input  logic [15:0]   addr,
  input  logic [63:0]   wr_data,
  output logic          rd_hit,
  output logic [63:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  // Status word layout: occupancy in [31:16], flags in [3:0].
  function automatic logic [63:0] status_word(input logic [CW-1:0] cnt,
                                              input logic udf, input logic ovf,
                                              input logic is_full, input logic is_empty);
    status_word = {32'h0000_0000, 16'(cnt), 12'h000, udf, ovf, is_full, is_empty};
  endfunction

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          ovf_r;
  logic          udf_r;

  logic          push_req_s;
  logic          pop_req_s;
  logic          stat_req_s;
  logic          ctrl_req_s;
  logic          pop_ok_s;
  logic          push_ok_s;
  logic          flush_s;
  logic          clr_s;

  logic [AW-1:0] wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic          ovf_nxt_s;
  logic          udf_nxt_s;
  logic          rd_hit_nxt_s;
  logic [63:0]   rd_data_nxt_s;

  assign push_req_s = wr_valid && (addr == DATA_ADDR);
  assign pop_req_s  = rd_valid && (addr == DATA_ADDR);
  assign stat_req_s = rd_valid && (addr == STATUS_ADDR);
  assign ctrl_req_s = wr_valid && (addr == CTRL_ADDR);

  // A pop that succeeds frees a slot, so a push into a full queue is still accepted.
  assign pop_ok_s   = pop_req_s && !empty;
  assign push_ok_s  = push_req_s && (!full || pop_ok_s);
  assign flush_s    = ctrl_req_s && wr_data[0];
  assign clr_s      = ctrl_req_s && wr_data[1];

  // Next pointers and occupancy. A flush overrides any pop/push update in the same cycle.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count;
    if (flush_s) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_nxt_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_nxt_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_nxt_s = count + CW'(1);
        2'b01:   count_nxt_s = count - CW'(1);
        default: count_nxt_s = count;
      endcase
    end
  end

  // Sticky overflow/underflow flags. A clear and a set cannot coincide, because the address differs.
  always_comb begin
    ovf_nxt_s = ovf_r;
    udf_nxt_s = udf_r;
    if (clr_s) begin
      ovf_nxt_s = 1'b0;
      udf_nxt_s = 1'b0;
    end else begin
      if (push_req_s && !push_ok_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r;
      end
      if (pop_req_s && !pop_ok_s) begin
        udf_nxt_s = 1'b1;
      end else begin
        udf_nxt_s = udf_r;
      end
    end
  end

  // Read response, built from pre-edge state. A miss keeps the last data.
  always_comb begin
    rd_hit_nxt_s  = 1'b0;
    rd_data_nxt_s = rd_data;
    if (pop_req_s) begin
      rd_hit_nxt_s = 1'b1;
      if (pop_ok_s) begin
        rd_data_nxt_s = mem_r[rd_ptr_r];
      end else begin
        rd_data_nxt_s = 64'h0;
      end
    end else if (stat_req_s) begin
      rd_hit_nxt_s  = 1'b1;
      rd_data_nxt_s = status_word(count, udf_r, ovf_r, full, empty);
    end else begin
      rd_hit_nxt_s  = 1'b0;
      rd_data_nxt_s = rd_data;
    end
  end

  // Control state and registered outputs. empty/full are registered from the next count, so they do not glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= 64'h0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count    <= count_nxt_s;
      empty    <= (count_nxt_s == {CW{1'b0}});
      full     <= (count_nxt_s == CW'(DEPTH));
      ovf_r    <= ovf_nxt_s;
      udf_r    <= udf_nxt_s;
      rd_hit   <= rd_hit_nxt_s;
      rd_data  <= rd_data_nxt_s;
    end
  end

  // Storage array write. The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mmio_wr_fifo.sv
// tb_mmio_wr_fifo: directed and random checks of mmio_wr_fifo.
// The reference is a queue-based model that is compared every cycle.
module tb_mmio_wr_fifo;

  localparam int unsigned DEPTH  = 8;
  localparam logic [15:0] DATA_A = 16'h0020;
  localparam logic [15:0] STAT_A = 16'h0022;
  localparam logic [15:0] CTRL_A = 16'h0024;
  localparam logic [15:0] OTHR_A = 16'h0030;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [63:0] wr_data = 64'h0;
  logic        rd_hit;
  logic [63:0] rd_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [63:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic        m_hit = 1'b0;
  logic [63:0] m_data = 64'h0;

  mmio_wr_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .rd_valid(rd_valid),
    .addr(addr), .wr_data(wr_data), .rd_hit(rd_hit), .rd_data(rd_data),
    .count(count), .empty(empty), .full(full)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s = 64'h0;
    s[31:16] = 16'(mq.size());
    s[3] = m_udf;
    s[2] = m_ovf;
    s[1] = (mq.size() == DEPTH);
    s[0] = (mq.size() == 0);
    return s;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_hit = 1'b0;
    m_data = 64'h0;
  endfunction

  // Compare DUT outputs against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_hit", {63'h0, rd_hit}, {63'h0, m_hit});
      check("rd_data", rd_data, m_data);
      check("count", {60'h0, count}, 64'(mq.size()));
      check("empty", {63'h0, empty}, {63'h0, mq.size() == 0});
      check("full", {63'h0, full}, {63'h0, mq.size() == DEPTH});
    end
  end

  // Drive one cycle, then advance the model across the clock edge
  task automatic step(input logic wv, input logic rv, input logic [15:0] a, input logic [63:0] d);
    logic        n_hit;
    logic [63:0] n_data;
    logic        push;
    logic        pop;
    wr_valid = wv;
    rd_valid = rv;
    addr = a;
    wr_data = d;
    push = wv && (a == DATA_A);
    pop  = rv && (a == DATA_A);
    n_hit  = rv && ((a == DATA_A) || (a == STAT_A));
    n_data = m_data;
    if (pop) n_data = (mq.size() > 0) ? mq[0] : 64'h0;
    else if (rv && (a == STAT_A)) n_data = m_status();
    @(posedge clk);
    #1;
    if (pop) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_udf = 1'b1;
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    if (wv && (a == CTRL_A)) begin
      if (d[0]) mq.delete();
      if (d[1]) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end
    m_hit = n_hit;
    m_data = n_data;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    step(1'b1, 1'b0, DATA_A, d);
  endtask

  task automatic pop_expect(input string name, input logic [63:0] v);
    step(1'b0, 1'b1, DATA_A, 64'h0);
    check(name, rd_data, v);
    check({name, "_hit"}, {63'h0, rd_hit}, 64'h1);
  endtask

  task automatic status_expect(input string name, input logic [63:0] v);
    step(1'b0, 1'b1, STAT_A, 64'h0);
    check(name, rd_data, v);
    check({name, "_model"}, m_data, v);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    int r;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_hit", {63'h0, rd_hit}, 64'h0);
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_count", {60'h0, count}, 64'h0);
    check("rst_empty", {63'h0, empty}, 64'h1);
    check("rst_full", {63'h0, full}, 64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    status_expect("status_after_reset", 64'h1);

    // In-order push/pop of three words
    push(64'hA1);
    push(64'hA2);
    push(64'hA3);
    pop_expect("pop_a1", 64'hA1);
    pop_expect("pop_a2", 64'hA2);
    pop_expect("pop_a3", 64'hA3);
    check("drained_count", {60'h0, count}, 64'h0);
    check("drained_empty", {63'h0, empty}, 64'h1);

    // Overflow: the ninth word is dropped
    for (int i = 1; i <= 9; i++) push(64'(i));
    check("full_flag", {63'h0, full}, 64'h1);
    check("full_count", {60'h0, count}, 64'h8);
    status_expect("status_full_ovf", 64'h0008_0006);
    for (int i = 1; i <= 8; i++) pop_expect("pop_ovf_seq", 64'(i));

    // Underflow, then clear the flags
    pop_expect("pop_empty", 64'h0);
    step(1'b0, 1'b1, STAT_A, 64'h0);
    check("udf_bit3", {63'h0, rd_data[3]}, 64'h1);
    step(1'b1, 1'b0, CTRL_A, 64'h2);
    status_expect("status_cleared", 64'h1);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) push(64'(100 + i));
    step(1'b1, 1'b1, DATA_A, 64'hBEEF);
    check("pushpop_full_data", rd_data, 64'd100);
    check("pushpop_full_count", {60'h0, count}, 64'h8);
    status_expect("status_pushpop_full", 64'h0008_0002);
    for (int i = 1; i < 8; i++) pop_expect("drain_seq", 64'(100 + i));
    pop_expect("drain_beef_last", 64'hBEEF);

    // Push and pop in the same cycle while empty: no bypass
    step(1'b1, 1'b1, DATA_A, 64'h77);
    check("pushpop_empty_data", rd_data, 64'h0);
    check("pushpop_empty_count", {60'h0, count}, 64'h1);
    pop_expect("pushpop_empty_stored", 64'h77);
    step(1'b1, 1'b0, CTRL_A, 64'h2);

    // Pointer wrap
    for (int i = 0; i < 5; i++) push(64'(200 + i));
    for (int i = 0; i < 3; i++) pop_expect("wrap_pop_a", 64'(200 + i));
    for (int i = 5; i < 11; i++) push(64'(200 + i));
    for (int i = 3; i < 11; i++) pop_expect("wrap_pop_b", 64'(200 + i));

    // A read of another address misses and keeps rd_data
    step(1'b0, 1'b1, OTHR_A, 64'h0);
    check("other_rd_hit", {63'h0, rd_hit}, 64'h0);
    check("other_rd_data", rd_data, 64'd210);

    // Mid-stream flush
    push(64'h11);
    push(64'h22);
    push(64'h33);
    step(1'b1, 1'b0, CTRL_A, 64'h1);
    check("flush_count", {60'h0, count}, 64'h0);
    push(64'h44);
    pop_expect("after_flush", 64'h44);

    // Asynchronous reset while a read is pending
    push(64'h55);
    push(64'h66);
    rd_valid = 1'b1;
    addr = DATA_A;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_count", {60'h0, count}, 64'h0);
    @(posedge clk);
    #1;
    check("rst_mid_rd_hit", {63'h0, rd_hit}, 64'h0);
    rd_valid = 1'b0;
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = DATA_A;
      else if (r < 8) a = STAT_A;
      else if (r == 8) a = CTRL_A;
      else a = OTHR_A;
      d = {$urandom, $urandom};
      if ((a == CTRL_A) && ($urandom_range(0, 7) != 0)) d[0] = 1'b0;
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1), a, d);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
